// File: rtl/rect_draw_engine.sv
// rect_draw_engine
//   Takes one rectangle command (origin, size, colour, erase flag) and
//   streams it one pixel per clock into the vga_adapter plot interface.
//   Pixels that fall outside the visible screen still take their cycle but
//   are emitted with writeEn low. A start/busy/done handshake frames each
//   command.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   start     in   command strobe, only looked at while idle
//   x_in      in   rectangle origin column
//   y_in      in   rectangle origin row
//   w_in      in   rectangle width in pixels
//   h_in      in   rectangle height in pixels
//   color_in  in   fill colour
//   erase     in   1 = fill with BG_COLOR instead of color_in
//   busy      out  command in progress (drawing or finishing)
//   done      out  one-cycle pulse when a command completes
//   x         out  pixel column to vga_adapter
//   y         out  pixel row to vga_adapter
//   colour    out  pixel colour to vga_adapter
//   writeEn   out  plot strobe to vga_adapter
module rect_draw_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SIZE_W   = 5,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int BG_COLOR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [SIZE_W-1:0]  w_in,
  input  logic [SIZE_W-1:0]  h_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               erase,
  output logic               busy,
  output logic               done,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] colour,
  output logic               writeEn
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [X_W:0]       SCR_W_L = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]       SCR_H_L = (Y_W+1)'(SCREEN_H);
  localparam logic [COLOR_W-1:0] BG_L    = COLOR_W'(BG_COLOR);
  localparam logic [SIZE_W-1:0]  ONE_S   = SIZE_W'(1);

  state_t              state_q, state_d;
  logic [X_W-1:0]      x0_q, x0_d;
  logic [Y_W-1:0]      y0_q, y0_d;
  logic [SIZE_W-1:0]   w_q, w_d;
  logic [SIZE_W-1:0]   h_q, h_d;
  logic [SIZE_W-1:0]   cx_q, cx_d;
  logic [SIZE_W-1:0]   cy_q, cy_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOR_W-1:0]  colour_q, colour_d;
  logic                we_q, we_d;

  // Pixel coordinates carry one extra bit so that an origin near the top of
  // the coordinate range plus an offset never wraps back onto the screen.
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;

  function automatic logic on_screen(input logic [X_W:0] sx, input logic [Y_W:0] sy);
    return (sx < SCR_W_L) && (sy < SCR_H_L);
  endfunction

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    we_d     = 1'b0;
    sum_x    = '0;
    sum_y    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d = x_in;
          y0_d = y_in;
          w_d  = w_in;
          h_d  = h_in;
          cx_d = '0;
          cy_d = '0;
          if ((w_in == '0) || (h_in == '0)) begin
            state_d = FIN;
          end else begin
            // The first pixel is loaded on the accepting edge so pixel k is
            // presented in the k+1'th cycle after start.
            state_d  = DRAW;
            sum_x    = {1'b0, x_in};
            sum_y    = {1'b0, y_in};
            x_d      = x_in;
            y_d      = y_in;
            colour_d = erase ? BG_L : color_in;
            we_d     = on_screen(sum_x, sum_y);
          end
        end
      end

      DRAW: begin
        // cx/cy name the pixel currently on the outputs; advance row-major.
        if (cx_q == w_q - ONE_S) begin
          if (cy_q == h_q - ONE_S) begin
            state_d = FIN;
          end else begin
            cx_d = '0;
            cy_d = cy_q + ONE_S;
          end
        end else begin
          cx_d = cx_q + ONE_S;
        end

        if (state_d == DRAW) begin
          sum_x = {1'b0, x0_q} + (X_W+1)'(cx_d);
          sum_y = {1'b0, y0_q} + (Y_W+1)'(cy_d);
          x_d   = sum_x[X_W-1:0];
          y_d   = sum_y[Y_W-1:0];
          we_d  = on_screen(sum_x, sum_y);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      we_q     <= we_d;
    end
  end

  // FIN lasts exactly one cycle, so decoding it gives the done pulse and
  // guarantees a start coincident with done is not accepted.
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);
  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign writeEn = we_q;

endmodule

// File: tb/tb_rect_draw_engine.sv
module tb_rect_draw_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [4:0] w_in;
  logic [4:0] h_in;
  logic [2:0] color_in;
  logic       erase;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn;

  int total = 0;
  int bad   = 0;

  rect_draw_engine #(
    .X_W(8), .Y_W(7), .COLOR_W(3), .SIZE_W(5),
    .SCREEN_W(160), .SCREEN_H(120), .BG_COLOR(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_in(x_in), .y_in(y_in), .w_in(w_in), .h_in(h_in),
    .color_in(color_in), .erase(erase),
    .busy(busy), .done(done), .x(x), .y(y),
    .colour(colour), .writeEn(writeEn)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [4:0] w;
    logic [4:0] h;
    logic [2:0] col;
    logic       er;
    int         exp_writes;
    int         exp_done;
    logic [2:0] exp_col;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command and follow it to completion. Called at a negedge with
  // the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_vec(input vec_t v);
    int n, writes, done_cyc, i, j, sx, sy;
    logic ew;
    n        = int'(v.w) * int'(v.h);
    writes   = 0;
    done_cyc = 0;
    x_in = v.x; y_in = v.y; w_in = v.w; h_in = v.h;
    color_in = v.col; erase = v.er; start = 1'b1;
    @(negedge clk);
    // Scramble inputs: only values sampled at acceptance may matter.
    start = 1'b0; x_in = ~v.x; y_in = ~v.y; w_in = ~v.w; h_in = ~v.h;
    color_in = ~v.col; erase = ~v.er;
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      if (c <= n) begin
        i  = (c - 1) % int'(v.w);
        j  = (c - 1) / int'(v.w);
        sx = int'(v.x) + i;
        sy = int'(v.y) + j;
        ew = (sx < 160) && (sy < 120);
        chk("pixel", {13'd0, writeEn, x, y, colour},
            {13'd0, ew, sx[7:0], sy[6:0], v.exp_col});
      end
      chk("busy", {31'd0, busy}, {31'd0, (c <= v.exp_done)});
      if (c > n) chk("we_off", {31'd0, writeEn}, 32'd0);
      if (writeEn) writes++;
      if (done && done_cyc == 0) done_cyc = c;
      @(negedge clk);
    end
    chk("done_cycle", done_cyc, v.exp_done);
    chk("write_count", writes, v.exp_writes);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'd10,  7'd20,  5'd3,  5'd2,  3'd4, 1'b0, 6, 7,   3'd4};
    vecs[1] = '{8'd0,   7'd0,   5'd1,  5'd1,  3'd7, 1'b1, 1, 2,   3'd0};
    vecs[2] = '{8'd158, 7'd118, 5'd4,  5'd4,  3'd5, 1'b0, 4, 17,  3'd5};
    vecs[3] = '{8'd0,   7'd0,   5'd0,  5'd5,  3'd3, 1'b0, 0, 1,   3'd0};
    vecs[4] = '{8'd159, 7'd119, 5'd31, 5'd31, 3'd2, 1'b0, 1, 962, 3'd2};
    vecs[5] = '{8'd5,   7'd5,   5'd5,  5'd0,  3'd1, 1'b0, 0, 1,   3'd0};
    vecs[6] = '{8'd254, 7'd5,   5'd4,  5'd1,  3'd1, 1'b0, 0, 5,   3'd1};
    vecs[7] = '{8'd2,   7'd3,   5'd2,  5'd3,  3'd6, 1'b0, 6, 7,   3'd6};

    reset = 1'b1; start = 1'b0; x_in = '0; y_in = '0; w_in = '0; h_in = '0;
    color_in = '0; erase = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {13'd0, busy, done, writeEn, x, y, colour}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Starts during DRAW and during the done cycle are dropped; the cycle
    // after done accepts a new command.
    x_in = 8'd1; y_in = 7'd1; w_in = 5'd2; h_in = 5'd2; color_in = 3'd6;
    erase = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 9; c++) begin
      start = 1'b0;
      case (c)
        1: chk("ign_p0", {writeEn, x, y, colour, busy}, {1'b1, 8'd1, 7'd1, 3'd6, 1'b1});
        2: chk("ign_p1", {writeEn, x, y, colour, busy}, {1'b1, 8'd2, 7'd1, 3'd6, 1'b1});
        3: begin
          start = 1'b1; x_in = 8'd50; y_in = 7'd50; w_in = 5'd1; h_in = 5'd1;
          chk("ign_p2", {writeEn, x, y, colour, busy}, {1'b1, 8'd1, 7'd2, 3'd6, 1'b1});
        end
        4: chk("ign_p3", {writeEn, x, y, colour, busy}, {1'b1, 8'd2, 7'd2, 3'd6, 1'b1});
        5: begin
          start = 1'b1; x_in = 8'd50; y_in = 7'd50; w_in = 5'd1; h_in = 5'd1;
          chk("ign_done", {29'd0, busy, done, writeEn}, {29'd0, 3'b110});
        end
        6: begin
          start = 1'b1; x_in = 8'd40; y_in = 7'd40; w_in = 5'd1; h_in = 5'd1;
          color_in = 3'd5;
          chk("ign_idle", {29'd0, busy, done, writeEn}, {29'd0, 3'b000});
        end
        7: chk("acc_pix", {writeEn, x, y, colour, busy}, {1'b1, 8'd40, 7'd40, 3'd5, 1'b1});
        8: chk("acc_done", {29'd0, busy, done, writeEn}, {29'd0, 3'b110});
        default: chk("acc_idle", {29'd0, busy, done, writeEn}, {29'd0, 3'b000});
      endcase
      @(negedge clk);
    end

    // Reset in the middle of a 4x4 command.
    x_in = 8'd0; y_in = 7'd0; w_in = 5'd4; h_in = 5'd4; color_in = 3'd2;
    erase = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c < 4) begin
        chk("rst_pre", {writeEn, x, y}, {1'b1, 8'(c - 1), 7'd0});
      end else if (c == 4) begin
        reset = 1'b1;
        chk("rst_pre", {writeEn, x, y}, {1'b1, 8'd3, 7'd0});
      end else begin
        reset = 1'b0;
        chk("rst_quiet", {29'd0, busy, done, writeEn}, {29'd0, 3'b000});
      end
      @(negedge clk);
    end
    run_vec('{8'd7, 7'd8, 5'd1, 5'd2, 3'd3, 1'b0, 2, 3, 3'd3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
